// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// FSM state encoding and the width of the single adder slice.
package mp_add_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// One SLICE_W-bit ripple-carry adder slice; the sequencer time-shares it
// across all bytes of the operands.
module ripple_carry_adder
    import mp_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cy_in,
    output logic [SLICE_W-1:0] sum,
    output logic               cy_out
);

    logic [SLICE_W:0] cy;

    assign cy[0] = cy_in;

    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
            assign sum[gi]  = a[gi] ^ b[gi] ^ cy[gi];
            assign cy[gi+1] = (a[gi] & b[gi]) | (cy[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cy_out = cy[SLICE_W];

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract: processes one byte per clock through a single
// shared adder slice, LSB first, with the carry held in a register between bytes.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] op_a,
    input  logic [SLICE_W*WORDS-1:0] op_b,
    input  logic                     cin,
    input  logic                     sub,
    output logic [SLICE_W*WORDS-1:0] result,
    output logic                     cout,
    output logic                     ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t state_reg, state_next;

    logic [IDX_W-1:0]   idx_reg;
    logic [W-1:0]       a_reg, b_reg;
    logic [W-1:0]       result_reg, result_next;
    logic               carry_reg, cout_reg, ovf_reg;

    logic [SLICE_W-1:0] a_bytes [WORDS];
    logic [SLICE_W-1:0] b_bytes [WORDS];
    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_cy_out, msb_cy_in;
    logic               accept, last_slice;

    assign accept     = (state_reg == IDLE) && in_valid;
    assign last_slice = (state_reg == RUN) && (idx_reg == LAST_IDX);

    // Byte lanes of the captured operands, and the byte-wise result write-back.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
            assign a_bytes[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_bytes[gi] = b_reg[gi*SLICE_W +: SLICE_W];
            assign result_next[gi*SLICE_W +: SLICE_W] =
                ((state_reg == RUN) && (idx_reg == IDX_W'(gi))) ?
                slice_sum : result_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign slice_a = a_bytes[idx_reg];
    assign slice_b = b_bytes[idx_reg];

    ripple_carry_adder u_slice (
        .a      (slice_a),
        .b      (slice_b),
        .cy_in  (carry_reg),
        .sum    (slice_sum),
        .cy_out (slice_cy_out)
    );

    // Carry into the top bit recovered from the sum bit, so no second adder is needed.
    assign msb_cy_in = slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_sum[SLICE_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            carry_reg  <= 1'b0;
            idx_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            result_reg <= result_next;
            if (accept) begin
                a_reg     <= op_a;
                b_reg     <= sub ? ~op_b : op_b;
                carry_reg <= sub ? 1'b1 : cin;
                idx_reg   <= '0;
            end else if (state_reg == RUN) begin
                carry_reg <= slice_cy_out;
                if (last_slice) begin
                    cout_reg <= slice_cy_out;
                    ovf_reg  <= msb_cy_in ^ slice_cy_out;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    assign result = result_reg;
    assign cout   = cout_reg;
    assign ovf    = ovf_reg;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed-vector bench for mp_add_sequencer (WORDS=4): arithmetic results,
// latency, output hold under back-pressure, and asynchronous reset abort.
module tb_mp_add_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cin;
    logic        sub;
    logic [31:0] result;
    logic        cout;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks;
    int errors;

    mp_add_sequencer #(.WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and counts rising edges until out_valid (-1 on timeout).
    // Inputs are scrambled right after acceptance so any use of live inputs shows up.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        op_a     = a;
        op_b     = b;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        cin      = ~c;
        sub      = ~s;
        lat      = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        $display("REQ a=%08h b=%08h cin=%0b sub=%0b -> result=%08h cout=%0b ovf=%0b lat=%0d",
                 a, b, c, s, result, cout, ovf, lat);
    endtask

    // Accepts the result with in_valid held high across the release edge.
    task automatic do_release();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%08h exp=00000000", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%0b exp=0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        $display("TEST reset done");
    endtask

    task automatic test_add();
        int lat;
        do_req(32'h00000005, 32'h00000007, 1'b0, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got=%0d exp=4", lat); end
        checks++; if (result !== 32'h0000000C) begin errors++; $display("FAIL add_result got=%08h exp=0000000c", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cout got=%0b exp=0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf got=%0b exp=0", ovf); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_done_flags in_ready=%0b busy=%0b exp in_ready=0 busy=1", in_ready, busy); end
        do_release();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_release out_valid=%0b busy=%0b in_ready=%0b exp 0 0 1", out_valid, busy, in_ready); end
    endtask

    task automatic test_carry_chain();
        int lat;
        do_req(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
        checks++; if (result !== 32'h00000000) begin errors++; $display("FAIL carry_result got=%08h exp=00000000", result); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL carry_cout got=%0b exp=1", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL carry_ovf got=%0b exp=0", ovf); end
        do_release();
        do_req(32'h000000FF, 32'h00000000, 1'b1, 1'b0, lat);
        checks++; if (result !== 32'h00000100 || cout !== 1'b0) begin errors++; $display("FAIL cin_result got=%08h cout=%0b exp=00000100 cout=0", result, cout); end
        do_release();
    endtask

    task automatic test_sub();
        int lat;
        do_req(32'h00000005, 32'h00000007, 1'b1, 1'b1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency got=%0d exp=4", lat); end
        checks++; if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_result got=%08h exp=fffffffe", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub_cout got=%0b exp=0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_ovf got=%0b exp=0", ovf); end
        do_release();
        do_req(32'h80000000, 32'h00000001, 1'b0, 1'b1, lat);
        checks++; if (result !== 32'h7FFFFFFF) begin errors++; $display("FAIL sub_ovf_result got=%08h exp=7fffffff", result); end
        checks++; if (cout !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL sub_ovf_flags cout=%0b ovf=%0b exp cout=1 ovf=1", cout, ovf); end
        do_release();
    endtask

    task automatic test_overflow();
        int lat;
        do_req(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
        checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL ovf_result got=%08h exp=80000000", result); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", ovf); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ovf_cout got=%0b exp=0", cout); end
        do_release();
    endtask

    task automatic test_hold();
        int lat;
        do_req(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
        checks++; if (result !== 32'h23456789) begin errors++; $display("FAIL hold_result got=%08h exp=23456789", result); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            op_a     = 32'hA5A5A5A5 ^ 32'(i);
            op_b     = 32'h5A5A5A5A + 32'(i);
            cin      = ~cin;
            sub      = ~sub;
            @(posedge clk);
            #1;
            checks++;
            if (result !== 32'h23456789 || cout !== 1'b0 || ovf !== 1'b0 ||
                out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d result=%08h cout=%0b ovf=%0b out_valid=%0b in_ready=%0b exp 23456789 0 0 1 0",
                         i, result, cout, ovf, out_valid, in_ready);
            end
            $display("HOLD cycle=%0d result=%08h out_valid=%0b in_ready=%0b", i, result, out_valid, in_ready);
        end
        do_release();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release out_valid=%0b busy=%0b in_ready=%0b exp 0 0 1", out_valid, busy, in_ready); end
        checks++; if (result !== 32'h23456789) begin errors++; $display("FAIL idle_retain got=%08h exp=23456789", result); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_req(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lat);
        checks++; if (result !== 32'h00000100 || cout !== 1'b0) begin errors++; $display("FAIL b2b_first got=%08h cout=%0b exp=00000100 cout=0", result, cout); end
        do_release();
        do_req(32'h00010000, 32'h00000001, 1'b0, 1'b1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
        checks++; if (result !== 32'h0000FFFF || cout !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL b2b_second got=%08h cout=%0b ovf=%0b exp=0000ffff cout=1 ovf=0", result, cout, ovf); end
        do_release();
    endtask

    task automatic test_reset_abort();
        int lat;
        logic seen_valid;
        @(negedge clk);
        op_a     = 32'h01010101;
        op_b     = 32'h01010101;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_midrun_busy got=%0b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs result=%08h cout=%0b ovf=%0b out_valid=%0b busy=%0b exp all 0",
                     result, cout, ovf, out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%0b exp=1", in_ready); end
        seen_valid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL abort_no_out_valid got=%0b exp=0", seen_valid); end
        $display("ABORT reset applied mid-run, out_valid seen=%0b", seen_valid);
        do_req(32'h00000080, 32'h00000095, 1'b1, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL post_abort_latency got=%0d exp=4", lat); end
        checks++; if (result !== 32'h00000116 || cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL post_abort_result got=%08h cout=%0b ovf=%0b exp=00000116 cout=0 ovf=0", result, cout, ovf); end
        do_release();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        rst_n     = 1'b1;
        test_reset();
        test_add();
        test_carry_chain();
        test_sub();
        test_overflow();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
